pbus_master_arb: RTL and testbench

Multi-requester master for the APB-like peripheral bus (pbus). Sits upstream of the pbus slave bridge and shares the single pbus between NUM_REQ internal requesters, such as the host-register path and the PTP servo/sequencer. Requests are granted round-robin. Each granted request runs as a two-phase SETUP/ACCESS transfer with wait-state support and a timeout. The block returns read data, a one-cycle acknowledge and an error flag to the requester.

---
 rtl/pbus_master_arb.sv | 157 +++++++++++++++
 tb/tb_pbus_master_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pbus_master_arb.sv
// Round-robin pbus master: shares one APB-like pbus among NUM_REQ requesters,
// running SETUP/ACCESS transfers with wait states and an ACCESS-phase timeout.
module pbus_master_arb #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  pbus_clk,
    input  logic                  pbus_rst,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    we_i,
    input  logic [32*NUM_REQ-1:0] addr_i,
    input  logic [32*NUM_REQ-1:0] wdata_i,
    output logic [NUM_REQ-1:0]    ack_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [31:0]           pbus_addr_o,
    output logic                  pbus_write_o,
    output logic                  pbus_sel_o,
    output logic                  pbus_enable_o,
    output logic [31:0]           pbus_wdata_o,
    input  logic [31:0]           pbus_rdata_i,
    input  logic                  pbus_ready_i,
    input  logic                  pbus_slverr_i
);

    localparam int unsigned NR = NUM_REQ;
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t              state_q, state_n;
    logic [GW-1:0]       g_q, g_n;
    logic [GW-1:0]       last_g_q, last_g_n;
    logic [CW-1:0]       cnt_q, cnt_n;
    logic [NUM_REQ-1:0]  ack_n;
    logic [31:0]         rdata_n, addr_n, wdata_n;
    logic                err_n, busy_n, write_n, sel_n, enable_n;

    logic                found;
    logic [GW-1:0]       pick;
    logic [31:0]         pick_addr, pick_wdata;

    // Round-robin: first requester strictly after last_g_q, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = last_g_q;
        for (int unsigned i = 1; i <= NR; i++) begin
            int unsigned tmp;
            logic [GW-1:0] cand;
            tmp = 32'(last_g_q) + i;
            if (tmp >= NR) tmp = tmp - NR;
            cand = GW'(tmp);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (pick == GW'(i)) begin
                pick_addr  = addr_i[32*i +: 32];
                pick_wdata = wdata_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_n  = state_q;
        g_n      = g_q;
        last_g_n = last_g_q;
        cnt_n    = cnt_q;
        ack_n    = '0;
        rdata_n  = rdata_o;
        err_n    = err_o;
        addr_n   = pbus_addr_o;
        write_n  = pbus_write_o;
        sel_n    = pbus_sel_o;
        enable_n = pbus_enable_o;
        wdata_n  = pbus_wdata_o;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    g_n     = pick;
                    addr_n  = pick_addr;
                    write_n = we_i[pick];
                    wdata_n = pick_wdata;
                    sel_n   = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                cnt_n    = '0;
                enable_n = 1'b1;
                state_n  = ACCESS;
            end
            ACCESS: begin
                if (pbus_ready_i || cnt_q == CW'(TIMEOUT - 1)) begin
                    // Ready on the final allowed cycle still counts as a normal completion.
                    rdata_n    = (pbus_ready_i && !pbus_write_o) ? pbus_rdata_i : '0;
                    err_n      = pbus_ready_i ? pbus_slverr_i : 1'b1;
                    ack_n[g_q] = 1'b1;
                    sel_n      = 1'b0;
                    enable_n   = 1'b0;
                    write_n    = 1'b0;
                    state_n    = DONE;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DONE: begin
                last_g_n = g_q;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge pbus_clk) begin
        if (pbus_rst) begin
            state_q       <= IDLE;
            g_q           <= '0;
            last_g_q      <= GW'(NUM_REQ - 1);
            cnt_q         <= '0;
            ack_o         <= '0;
            rdata_o       <= '0;
            err_o         <= 1'b0;
            busy_o        <= 1'b0;
            pbus_addr_o   <= '0;
            pbus_write_o  <= 1'b0;
            pbus_sel_o    <= 1'b0;
            pbus_enable_o <= 1'b0;
            pbus_wdata_o  <= '0;
        end else begin
            state_q       <= state_n;
            g_q           <= g_n;
            last_g_q      <= last_g_n;
            cnt_q         <= cnt_n;
            ack_o         <= ack_n;
            rdata_o       <= rdata_n;
            err_o         <= err_n;
            busy_o        <= busy_n;
            pbus_addr_o   <= addr_n;
            pbus_write_o  <= write_n;
            pbus_sel_o    <= sel_n;
            pbus_enable_o <= enable_n;
            pbus_wdata_o  <= wdata_n;
        end
    end

endmodule

// File: tb/tb_pbus_master_arb.sv
// Bench for pbus_master_arb: fixed vectors, contention/reset sequences and
// randomized transfers checked against a transaction-level model.
module tb_pbus_master_arb;

    localparam int NR = 2;
    localparam int T  = 16;

    logic            pbus_clk = 1'b0;
    logic            pbus_rst = 1'b1;
    logic [NR-1:0]   req_i = '0;
    logic [NR-1:0]   we_i;
    logic [32*NR-1:0] addr_i, wdata_i;
    logic [NR-1:0]   ack_o;
    logic [31:0]     rdata_o;
    logic            err_o, busy_o;
    logic [31:0]     pbus_addr_o, pbus_wdata_o;
    logic            pbus_write_o, pbus_sel_o, pbus_enable_o;
    logic [31:0]     pbus_rdata_i = '0;
    logic            pbus_ready_i = 1'b0;
    logic            pbus_slverr_i = 1'b0;

    logic            we_a [NR];
    logic [31:0]     addr_a [NR];
    logic [31:0]     wdata_a [NR];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_m = NR - 1;
    int last_ack_cyc = 0;

    assign we_i    = {we_a[1], we_a[0]};
    assign addr_i  = {addr_a[1], addr_a[0]};
    assign wdata_i = {wdata_a[1], wdata_a[0]};

    pbus_master_arb #(.NUM_REQ(NR), .TIMEOUT(T)) dut (
        .pbus_clk(pbus_clk), .pbus_rst(pbus_rst),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
        .pbus_addr_o(pbus_addr_o), .pbus_write_o(pbus_write_o),
        .pbus_sel_o(pbus_sel_o), .pbus_enable_o(pbus_enable_o),
        .pbus_wdata_o(pbus_wdata_o), .pbus_rdata_i(pbus_rdata_i),
        .pbus_ready_i(pbus_ready_i), .pbus_slverr_i(pbus_slverr_i)
    );

    always #5 pbus_clk = ~pbus_clk;
    always @(posedge pbus_clk) cyc <= cyc + 1;

    typedef struct {
        logic [NR-1:0] mask;
        int            waits;
        logic          slverr;
        logic [31:0]   brd;
        int            g;
        logic          err;
        logic [31:0]   rd;
        int            lat;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] mask, input int last);
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (last + k) % NR;
            if (mask[c]) return c;
        end
        return 0;
    endfunction

    // One transfer: waits = ACCESS cycles with ready low before ready goes high.
    task automatic xfer(input string nm, input logic [NR-1:0] mask, input int waits,
                        input logic slverr, input logic [31:0] brd, input int exp_g,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
        int n, acc, bw, encount;
        logic addr_ok, seen_ack;
        logic [NR-1:0] ea;
        req_i = mask;
        pbus_slverr_i = slverr;
        pbus_rdata_i = brd;
        pbus_ready_i = 1'b0;
        bw = 0;
        while (busy_o !== 1'b0 && bw < 50) begin
            @(posedge pbus_clk); #1; bw++;
        end
        chk({nm, "_idle"}, 32'(busy_o), 32'(0));
        n = 0; acc = 0; encount = 0; addr_ok = 1'b1; seen_ack = 1'b0;
        while (n < 60 && !seen_ack) begin
            @(posedge pbus_clk); #1; n++;
            if (ack_o != '0) begin
                seen_ack = 1'b1;
            end else begin
                pbus_ready_i = 1'b0;
                if (pbus_sel_o) begin
                    if (pbus_addr_o !== addr_a[exp_g] || pbus_write_o !== we_a[exp_g] ||
                        pbus_wdata_o !== wdata_a[exp_g]) addr_ok = 1'b0;
                    if (pbus_enable_o) begin
                        pbus_ready_i = (acc == waits);
                        acc++;
                        encount++;
                    end
                end
            end
        end
        pbus_ready_i = 1'b0;
        ea = '0;
        ea[exp_g] = 1'b1;
        chk({nm, "_ack"}, 32'(ack_o), 32'(ea));
        chk({nm, "_lat"}, n, exp_lat);
        chk({nm, "_rdata"}, rdata_o, exp_rd);
        chk({nm, "_err"}, 32'(err_o), 32'(exp_err));
        chk({nm, "_busfields"}, 32'(addr_ok), 32'(1));
        chk({nm, "_enable_cycles"}, encount, exp_lat - 2);
        chk({nm, "_done_bus"}, {28'(0), busy_o, pbus_sel_o, pbus_enable_o, pbus_write_o}, 32'h8);
        last_ack_cyc = cyc;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ack"}, 32'(ack_o), 32'(0));
        chk({nm, "_rdata"}, rdata_o, 32'(0));
        chk({nm, "_flags"}, {27'(0), err_o, busy_o, pbus_sel_o, pbus_enable_o, pbus_write_o}, 32'(0));
        chk({nm, "_addr"}, pbus_addr_o, 32'(0));
        chk({nm, "_wdata"}, pbus_wdata_o, 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, w, r, prev;
        logic [NR-1:0] m;
        logic se, e;
        logic [31:0] b, rd;

        tbl[0] = '{2'b01,  0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF,  3};
        tbl[1] = '{2'b10,  3, 1'b0, 32'hFFFF_FFFF, 1, 1'b0, 32'h0,          6};
        tbl[2] = '{2'b01, 16, 1'b0, 32'h5555_AAAA, 0, 1'b1, 32'h0,         18};
        tbl[3] = '{2'b01, 15, 1'b0, 32'h0BAD_F00D, 0, 1'b0, 32'h0BAD_F00D, 18};
        tbl[4] = '{2'b01,  1, 1'b1, 32'hCAFE_0001, 0, 1'b1, 32'hCAFE_0001,  4};
        tbl[5] = '{2'b11,  0, 1'b0, 32'h7777_0000, 1, 1'b0, 32'h0,          3};
        tbl[6] = '{2'b11,  0, 1'b0, 32'h1111_2222, 0, 1'b0, 32'h1111_2222,  3};
        tbl[7] = '{2'b11,  2, 1'b0, 32'h3333_4444, 1, 1'b0, 32'h0,          5};
        tbl[8] = '{2'b10,  2, 1'b1, 32'h0,         1, 1'b1, 32'h0,          5};

        we_a[0] = 1'b0; addr_a[0] = 32'h0000_0040; wdata_a[0] = 32'hA5A5_0000;
        we_a[1] = 1'b1; addr_a[1] = 32'h0000_1000; wdata_a[1] = 32'h1234_5678;

        req_i = 2'b11;
        repeat (3) @(posedge pbus_clk);
        #1;
        chk_all_zero("reset");
        req_i = '0;
        pbus_rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            xfer($sformatf("vec%0d", i), tbl[i].mask, tbl[i].waits, tbl[i].slverr, tbl[i].brd,
                 tbl[i].g, tbl[i].err, tbl[i].rd, tbl[i].lat);
            last_m = tbl[i].g;
        end

        // Contention: both requesters held, grants alternate, acks 4 cycles apart.
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            b = $urandom;
            g = rr_pick(2'b11, last_m);
            xfer($sformatf("cont%0d", i), 2'b11, 0, 1'b0, b, g, 1'b0,
                 we_a[g] ? 32'h0 : b, 3);
            if (i > 0) chk($sformatf("cont%0d_spacing", i), last_ack_cyc - prev, 4);
            prev = last_ack_cyc;
            last_m = g;
        end

        // Leave last grant at requester 0 with nonzero rdata/err, then reset mid-ACCESS.
        g = rr_pick(2'b01, last_m);
        xfer("pre_rst", 2'b01, 0, 1'b1, 32'hFACE_CAFE, g, 1'b1, 32'hFACE_CAFE, 3);
        last_m = g;
        req_i = 2'b01;
        pbus_ready_i = 1'b0;
        r = 0;
        while (!(pbus_sel_o && pbus_enable_o) && r < 20) begin
            @(posedge pbus_clk); #1; r++;
        end
        chk("rst_reached_access", 32'(pbus_enable_o), 32'(1));
        @(posedge pbus_clk); #1;
        pbus_rst = 1'b1;
        req_i = 2'b11;
        @(posedge pbus_clk); #1;
        chk_all_zero("rst_mid");
        @(posedge pbus_clk); #1;
        chk_all_zero("rst_hold");
        pbus_rst = 1'b0;
        last_m = NR - 1;
        g = rr_pick(2'b11, last_m);
        xfer("post_rst_first", 2'b11, 0, 1'b0, 32'h0101_0101, g, 1'b0, 32'h0101_0101, 3);
        last_m = g;
        g = rr_pick(2'b10, last_m);
        xfer("post_rst_req1", 2'b10, 1, 1'b0, 32'h0, g, 1'b0, 32'h0, 4);
        last_m = g;

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < NR; k++) begin
                we_a[k] = 1'($urandom);
                addr_a[k] = $urandom;
                wdata_a[k] = $urandom;
            end
            m = NR'($urandom_range(1, 3));
            r = $urandom_range(0, 9);
            w = (r < 7) ? r % 4 : (r == 7 ? 15 : (r == 8 ? 16 : 20));
            se = 1'($urandom);
            b = $urandom;
            g = rr_pick(m, last_m);
            e = (w >= T) ? 1'b1 : se;
            rd = (w >= T || we_a[g]) ? 32'h0 : b;
            xfer($sformatf("rnd%0d", i), m, w, se, b, g, e, rd, 3 + ((w < T) ? w : T - 1));
            last_m = g;
        end

        req_i = '0;
        repeat (3) @(posedge pbus_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
